// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: state codes, datapath mux selects
// and the opcode/funct values the controller decodes.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RESET      = 5'd0,
    ST_FETCH      = 5'd1,
    ST_FETCH_WAIT = 5'd2,
    ST_DECODE     = 5'd3,
    ST_EXEC_R     = 5'd4,
    ST_EXEC_I     = 5'd5,
    ST_WB_R       = 5'd6,
    ST_WB_I       = 5'd7,
    ST_MEM_ADDR   = 5'd8,
    ST_LD_WAIT    = 5'd9,
    ST_LD_WB      = 5'd10,
    ST_ST         = 5'd11,
    ST_BRANCH     = 5'd12,
    ST_JUMP       = 5'd13,
    ST_EXC_SAVE   = 5'd14,
    ST_EXC_JUMP   = 5'd15
  } state_e;

  localparam logic [2:0] ALU_PASS_A = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3;
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_A = 2'd1;
  localparam logic [2:0] SRCB_B = 3'd0, SRCB_FOUR = 3'd1, SRCB_IMM = 3'd2, SRCB_IMM_SH2 = 3'd3;
  localparam logic [2:0] PCSRC_ALU = 3'd0, PCSRC_ALUOUT = 3'd1, PCSRC_JUMP = 3'd2, PCSRC_EXC = 3'd3;
  localparam logic [2:0] IORD_PC = 3'd0, IORD_ALUOUT = 3'd1;
  localparam logic [1:0] REGDST_RT = 2'd0, REGDST_SP = 2'd1, REGDST_RD = 2'd3;
  localparam logic [2:0] M2R_ALUOUT = 3'd0, M2R_MDR = 3'd1, M2R_SP_INIT = 3'd3;
  localparam logic [1:0] EXC_ILLEGAL = 2'd0, EXC_OVERFLOW = 2'd1;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;

  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    case (opcode)
      OP_RTYPE: return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in, control strobes out.
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       zero;

  logic       pc_write, pc_write_cond, branch_ne, mem_write, ir_write, reg_write;
  logic       a_write, b_write, mdr_load, epc_write, aluout_write;
  logic [1:0] reg_dst, alu_src_a, exc_cause;
  logic [2:0] alu_src_b, alu_op, pc_source, mem_to_reg, iord;
  logic [4:0] state_out;

  modport ctrl (
    input  opcode, funct, overflow, zero,
    output pc_write, pc_write_cond, branch_ne, mem_write, ir_write, reg_write,
           a_write, b_write, mdr_load, epc_write, aluout_write,
           reg_dst, alu_src_a, exc_cause, alu_src_b, alu_op, pc_source,
           mem_to_reg, iord, state_out
  );

  modport dp (
    output opcode, funct, overflow, zero,
    input  pc_write, pc_write_cond, branch_ne, mem_write, ir_write, reg_write,
           a_write, b_write, mdr_load, epc_write, aluout_write,
           reg_dst, alu_src_a, exc_cause, alu_src_b, alu_op, pc_source,
           mem_to_reg, iord, state_out
  );
endinterface

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter that times memory latency; done is high while the count is zero.
module mem_wait_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (count_q != '0)
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control FSM: Moore decode of the state register (plus latency counter)
// into datapath control strobes and mux selects.
module mc_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int EXC_EN   = 1
) (
  input logic          clk,
  input logic          reset,
  mc_ctrl_fsm_if.ctrl  bus
);

  localparam logic [2:0] FETCH_LOAD = 3'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
  localparam logic [2:0] LD_LOAD    = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic       ctr_load, ctr_done;
  logic [2:0] ctr_val;
  logic       legal;

  assign legal    = is_legal(bus.opcode, bus.funct);
  assign ctr_load = (state_q == ST_FETCH) || (state_q == ST_MEM_ADDR);
  assign ctr_val  = (state_q == ST_FETCH) ? FETCH_LOAD : LD_LOAD;

  mem_wait_ctr #(.W(3)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .done     (ctr_done)
  );

  // IR is held stable through an instruction, so the exception cause is recovered from it:
  // a legal instruction can only trap on overflow.
  always_comb begin
    state_d           = state_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.a_write       = 1'b0;
    bus.b_write       = 1'b0;
    bus.mdr_load      = 1'b0;
    bus.epc_write     = 1'b0;
    bus.aluout_write  = 1'b0;
    bus.reg_dst       = REGDST_RT;
    bus.alu_src_a     = SRCA_PC;
    bus.alu_src_b     = SRCB_B;
    bus.alu_op        = ALU_PASS_A;
    bus.pc_source     = PCSRC_ALU;
    bus.mem_to_reg    = M2R_ALUOUT;
    bus.iord          = IORD_PC;
    bus.exc_cause     = EXC_ILLEGAL;
    bus.state_out     = state_q;

    case (state_q)
      ST_RESET: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = REGDST_SP;
        bus.mem_to_reg = M2R_SP_INIT;
        state_d        = ST_FETCH;
      end
      ST_FETCH: begin
        bus.pc_write  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALU_ADD;
        bus.ir_write  = (MEM_WAIT == 0);
        state_d       = (MEM_WAIT == 0) ? ST_DECODE : ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        bus.ir_write = ctr_done;
        if (ctr_done) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        bus.a_write      = 1'b1;
        bus.b_write      = 1'b1;
        bus.aluout_write = 1'b1;
        bus.alu_src_b    = SRCB_IMM_SH2;
        bus.alu_op       = ALU_ADD;
        if (!legal)
          state_d = (EXC_EN != 0) ? ST_EXC_SAVE : ST_FETCH;
        else begin
          case (bus.opcode)
            OP_RTYPE:       state_d = ST_EXEC_R;
            OP_ADDI:        state_d = ST_EXEC_I;
            OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = ST_BRANCH;
            default:        state_d = ST_JUMP;
          endcase
        end
      end
      ST_EXEC_R: begin
        bus.alu_src_a    = SRCA_A;
        bus.aluout_write = 1'b1;
        case (bus.funct)
          FN_SUB:  bus.alu_op = ALU_SUB;
          FN_AND:  bus.alu_op = ALU_AND;
          default: bus.alu_op = ALU_ADD;
        endcase
        state_d = ((EXC_EN != 0) && bus.overflow && (bus.funct != FN_AND)) ? ST_EXC_SAVE : ST_WB_R;
      end
      ST_EXEC_I: begin
        bus.alu_src_a    = SRCA_A;
        bus.alu_src_b    = SRCB_IMM;
        bus.alu_op       = ALU_ADD;
        bus.aluout_write = 1'b1;
        state_d = ((EXC_EN != 0) && bus.overflow) ? ST_EXC_SAVE : ST_WB_I;
      end
      ST_WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = REGDST_RD;
        state_d       = ST_FETCH;
      end
      ST_WB_I: begin
        bus.reg_write = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        bus.alu_src_a    = SRCA_A;
        bus.alu_src_b    = SRCB_IMM;
        bus.alu_op       = ALU_ADD;
        bus.aluout_write = 1'b1;
        state_d = (bus.opcode == OP_LW) ? ST_LD_WAIT : ST_ST;
      end
      ST_LD_WAIT: begin
        bus.iord     = IORD_ALUOUT;
        bus.mdr_load = ctr_done;
        if (ctr_done) state_d = ST_LD_WB;
      end
      ST_LD_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = M2R_MDR;
        state_d        = ST_FETCH;
      end
      ST_ST: begin
        bus.mem_write = 1'b1;
        bus.iord      = IORD_ALUOUT;
        state_d       = ST_FETCH;
      end
      ST_BRANCH: begin
        bus.pc_write_cond = 1'b1;
        bus.branch_ne     = (bus.opcode == OP_BNE);
        bus.alu_src_a     = SRCA_A;
        bus.alu_op        = ALU_SUB;
        bus.pc_source     = PCSRC_ALUOUT;
        state_d           = ST_FETCH;
      end
      ST_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
        state_d       = ST_FETCH;
      end
      ST_EXC_SAVE: begin
        bus.epc_write = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALU_SUB;
        bus.exc_cause = legal ? EXC_OVERFLOW : EXC_ILLEGAL;
        state_d       = ST_EXC_JUMP;
      end
      ST_EXC_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_EXC;
        bus.exc_cause = legal ? EXC_OVERFLOW : EXC_ILLEGAL;
        state_d       = ST_FETCH;
      end
      default: state_d = ST_RESET;
    endcase

    // Architectural writes are suppressed while reset is held so each fires exactly once.
    if (reset) begin
      bus.ir_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

endmodule
